// File: rtl/uart_pkg.sv
// uart_pkg: frame constants and receiver FSM states shared by the RX and TX UARTs
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: CPU-side pop port and status flags of the RX UART
interface uart_rx_if;
  logic re;
  logic [31:0] rdata;
  logic empty;
  logic full;
  logic frame_err;
  logic overrun;
  modport master(output re, input rdata, empty, full, frame_err, overrun);
  modport slave(input re, output rdata, empty, full, frame_err, overrun);
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO with wrap-bit pointers, shared by RX and TX UARTs
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  logic [PTR_WIDTH:0] wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  assign empty = wp == rp;
  assign full = wp == {~rp[PTR_WIDTH], rp[PTR_WIDTH-1:0]};
  assign rdata = empty ? '0 : mem[rp[PTR_WIDTH-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (we && !full) begin
        mem[wp[PTR_WIDTH-1:0]] <= wdata;
        wp <= wp + 1'b1;
      end
      if (re && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: serial receiver feeding a FWFT byte FIFO; 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined
module uart_rx import uart_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int UART_BAUD_DIV = 217,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  input logic rx,
  uart_rx_if.slave bus
);
  localparam int BW = $clog2(UART_BAUD_DIV);
  localparam int CW = $clog2(WIDTH + 1);
  uart_state_t state;
  logic rx_m, rx_s, push, full, frame_err, overrun, bit_end, stop_ok;
  logic [BW-1:0] bcnt;
  logic [CW-1:0] nbits;
  logic [WIDTH-1:0] shift, wbyte, head;
`ifdef UART_RX_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
  logic perr;
  assign stop_ok = rx_s == STOP_BIT && !perr;
`else
  localparam uart_state_t AFTER_DATA = STOP;
  assign stop_ok = rx_s == STOP_BIT;
`endif
  assign bit_end = bcnt == BW'(UART_BAUD_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      {rx_s, rx_m} <= 2'b11;
      state <= IDLE;
      bcnt <= '0;
      nbits <= '0;
      shift <= '0;
      wbyte <= '0;
      push <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr <= 1'b0;
`endif
    end else begin
      {rx_s, rx_m} <= {rx_m, rx};
      bcnt <= bcnt + 1'b1;
      push <= 1'b0;
      frame_err <= 1'b0;
      overrun <= push && full;
      case (state)
        IDLE: if (rx_s == START_BIT) begin
          state <= START;
          bcnt <= '0;
        end
        START: if (bcnt == BW'(UART_BAUD_DIV / 2 - 1)) begin
          state <= rx_s == START_BIT ? DATA : IDLE;
          bcnt <= '0;
          nbits <= '0;
        end
        DATA: if (bit_end) begin
          shift <= {rx_s, shift[WIDTH-1:1]};
          nbits <= nbits + 1'b1;
          bcnt <= '0;
          if (nbits == CW'(WIDTH - 1)) state <= AFTER_DATA;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (bit_end) begin
          perr <= rx_s != ^shift;
          state <= STOP;
          bcnt <= '0;
        end
`endif
        STOP: if (bit_end) begin
          push <= stop_ok;
          wbyte <= shift;
          frame_err <= !stop_ok;
          state <= IDLE;
          bcnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  uart_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) fifo (
    .clk(clk),
    .rst(rst),
    .we(push),
    .re(bus.re),
    .wdata(wbyte),
    .rdata(head),
    .empty(bus.empty),
    .full(full)
  );
  assign bus.full = full;
  assign bus.rdata = {{(32 - WIDTH){1'b0}}, head};
  assign bus.frame_err = frame_err;
  assign bus.overrun = overrun;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames checked every cycle against a queue-based model of the receiver
module tb_uart_rx;
  localparam int DIV = 217;
  localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // edge of the stop-bit sample, counted from the edge before the start bit is driven:
  // 2 synchronizer stages + 1 to leave idle, half a bit to mid start, one bit per data/parity/stop bit
  localparam int STOP_AT = 3 + DIV / 2 + (8 + PAR + 1) * DIV;
  typedef struct {int t; bit ok; logic [7:0] b;} ev_t;
  logic clk = 0, rst = 1, rx = 1;
  uart_rx_if bus();
  uart_rx #(.DEPTH(DEPTH), .UART_BAUD_DIV(DIV), .WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int total = 0, passed = 0, cyc = 0, nferr = 0, novr = 0, last_fall = 0;
  bit chk_on = 0, exp_ferr = 0, exp_ovr = 0, prev_empty = 1, done = 0;
  ev_t sched[$];
  logic [7:0] mq[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask
  always @(posedge clk) begin
    int occ;
    cyc++;
    exp_ferr = 0;
    exp_ovr = 0;
    if (rst) begin
      mq.delete();
      sched.delete();
    end else begin
      occ = mq.size();
      if (bus.re && occ > 0) void'(mq.pop_front());
      while (sched.size() > 0 && sched[0].t <= cyc) begin
        if (!sched[0].ok) exp_ferr = 1;
        else if (occ == DEPTH) exp_ovr = 1;
        else mq.push_back(sched[0].b);
        void'(sched.pop_front());
      end
    end
  end
  always @(negedge clk) if (chk_on) begin
    logic [35:0] e;
    e = {32'h0, mq.size() == 0, mq.size() == DEPTH, exp_ferr, exp_ovr};
    if (mq.size() != 0) e[35:4] = {24'h0, mq[0]};
    chk("outputs{rdata,empty,full,ferr,ovr}", {bus.rdata, bus.empty, bus.full, bus.frame_err, bus.overrun}, e);
    if (bus.frame_err) nferr++;
    if (bus.overrun) novr++;
    if (prev_empty && !bus.empty) last_fall = cyc;
    prev_empty = bus.empty;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bit_out(input logic v);
    rx = v;
    tick(DIV);
  endtask
  task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    ev_t e;
    e.ok = stop_ok && (PAR == 0 || par_ok);
    e.t = cyc + STOP_AT + (e.ok ? 1 : 0);
    e.b = b;
    sched.push_back(e);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    if (PAR != 0) bit_out(^b ^ !par_ok);
    bit_out(stop_ok);
    if (!stop_ok) bit_out(1'b1);
  endtask
  task automatic pop(input logic [31:0] exp);
    @(negedge clk);
    chk("pop_rdata", bus.rdata, exp);
    bus.re = 1;
    @(posedge clk);
    #1 bus.re = 0;
  endtask
  initial begin
    int t0, f0, o0;
    logic [7:0] b81;
    bus.re = 0;
    tick(3);
    rst = 0;
    chk_on = 1;
    @(negedge clk);
    chk("reset_empty", bus.empty, 1);
    chk("reset_full", bus.full, 0);
    chk("reset_rdata", bus.rdata, 0);
    chk("reset_pulses", {bus.frame_err, bus.overrun}, 0);
    tick(1);
    t0 = cyc;
    send(8'h55, 1, 1);
    chk("t1_empty_fall_near_10_bits", (last_fall - t0) >= DIV * 19 / 2 && (last_fall - t0) <= DIV * 10, 1);
    @(negedge clk);
    chk("t1_rdata", bus.rdata, 32'h55);
    pop(32'h55);
    @(negedge clk);
    chk("t1_empty_after_pop", bus.empty, 1);
    tick(1);
    f0 = nferr;
    send(8'hA5, 1, 1);
    send(8'h3C, 1, 1);
    pop(32'hA5);
    pop(32'h3C);
    chk("t2_no_frame_err", nferr - f0, 0);
    rx = 0;
    tick(50);
    rx = 1;
    tick(300);
    chk("t3_glitch_no_push", bus.empty, 1);
    chk("t3_glitch_no_err", nferr - f0, 0);
    send(8'hFF, 0, 1);
    chk("t4_one_frame_err", nferr - f0, 1);
    chk("t4_empty", bus.empty, 1);
    o0 = novr;
    for (int i = 0; i < 17; i++) send(8'(i), 1, 1);
    @(negedge clk);
    chk("t5_full", bus.full, 1);
    chk("t5_one_overrun", novr - o0, 1);
    for (int i = 0; i < 16; i++) pop(32'(i));
    @(negedge clk);
    chk("t5_empty", bus.empty, 1);
    tick(1);
    send(8'h11, 1, 1);
    send(8'h22, 1, 1);
    b81 = 8'h81;
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(b81[i]);
    rx = 0;
    tick(DIV / 2);
    rx = 1;
    rst = 1;
    tick(1);
    rst = 0;
    @(negedge clk);
    chk("t6_flushed", bus.empty, 1);
    chk("t6_no_err", bus.frame_err, 0);
    tick(1);
    send(8'h42, 1, 1);
    pop(32'h42);
    if (PAR != 0) begin
      f0 = nferr;
      send(8'h07, 1, 0);
      chk("t7_bad_parity_err", nferr - f0, 1);
      chk("t7_bad_parity_dropped", bus.empty, 1);
      send(8'h07, 1, 1);
      pop(32'h07);
    end
    tick(1);
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          send(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
          tick($urandom_range(0, 300));
        end
        done = 1;
      end
      begin
        while (!done) begin
          bus.re = $urandom_range(0, 7) == 0;
          tick(1);
        end
        bus.re = 1;
        tick(20);
        bus.re = 0;
      end
    join
    @(negedge clk);
    chk("final_drained", bus.empty, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
